// File: rtl/f2c_dma_sched.sv
// F2C ring DMA scheduler: slices the source QW stream into MWr TLPs per ring chunk
// and interleaves F2C/C2F pointer metric writes into the host metrics buffer.
module f2c_dma_sched #(
  parameter int CHUNK_SIZE = 1024,
  parameter int TLP_SIZE   = 128,
  parameter int NUM_CHUNKS = 4,
  localparam int PTR_W     = $clog2(NUM_CHUNKS)
) (
  input  logic             clk_in,
  input  logic             rstn,
  input  logic             dmaEnable_in,
  input  logic [31:0]      f2cBase_in,
  input  logic [31:0]      mtrBase_in,
  input  logic [PTR_W-1:0] rdPtr_in,
  input  logic [PTR_W-1:0] c2fRdPtr_in,
  input  logic             c2fRdPtrUpd_in,
  input  logic [63:0]      f2cData_in,
  input  logic             f2cValid_in,
  output logic             f2cReady_out,
  output logic             hdrValid_out,
  input  logic             hdrReady_in,
  output logic [63:0]      hdrAddr_out,
  output logic [9:0]       hdrDwCount_out,
  output logic             datValid_out,
  input  logic             datReady_in,
  output logic [63:0]      datData_out,
  output logic [PTR_W-1:0] wrPtr_out
);

  localparam int TLPS   = CHUNK_SIZE / TLP_SIZE;
  localparam int IDX_W  = (TLPS > 1) ? $clog2(TLPS) : 1;
  localparam int BEATS  = TLP_SIZE / 8;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {IDLE, DHDR, DBODY, MHDR, MBODY} state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [IDX_W-1:0]  tlp_idx;
  logic [BEAT_W-1:0] beat_cnt;
  logic              f2c_pend, c2f_pend, mtr_c2f;
  logic [63:0]       hdr_addr, mtr_data;
  logic [9:0]        hdr_dw;

  logic start_dat, start_f2c, start_c2f, beat_fire, dat_done, mtr_done;
  logic ring_full, last_beat, last_tlp;

  function automatic logic [63:0] data_addr(input logic [31:0] base,
                                            input logic [PTR_W-1:0] ptr,
                                            input logic [IDX_W-1:0] idx);
    return (64'(base) << 3) + 64'(ptr) * 64'(CHUNK_SIZE) + 64'(idx) * 64'(TLP_SIZE);
  endfunction

  assign ring_full = (wr_ptr + PTR_W'(1)) == rdPtr_in;
  assign last_beat = beat_cnt == BEAT_W'(BEATS - 1);
  assign last_tlp  = tlp_idx == IDX_W'(TLPS - 1);

  assign hdrAddr_out    = hdr_addr;
  assign hdrDwCount_out = hdr_dw;
  assign wrPtr_out      = wr_ptr;

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    start_dat    = 1'b0;
    start_f2c    = 1'b0;
    start_c2f    = 1'b0;
    beat_fire    = 1'b0;
    dat_done     = 1'b0;
    mtr_done     = 1'b0;
    hdrValid_out = 1'b0;
    datValid_out = 1'b0;
    f2cReady_out = 1'b0;
    datData_out  = f2cData_in;
    case (state)
      IDLE: begin
        // F2C pending is ignored while disabled; it is being cleared in that case
        if (dmaEnable_in && f2c_pend) begin
          start_f2c = 1'b1;
          state_nxt = MHDR;
        end else if (c2f_pend) begin
          start_c2f = 1'b1;
          state_nxt = MHDR;
        end else if (dmaEnable_in && !ring_full) begin
          start_dat = 1'b1;
          state_nxt = DHDR;
        end
      end
      DHDR: begin
        hdrValid_out = 1'b1;
        if (hdrReady_in) state_nxt = DBODY;
      end
      DBODY: begin
        datValid_out = f2cValid_in;
        f2cReady_out = datReady_in;
        beat_fire    = f2cValid_in && datReady_in;
        if (beat_fire && last_beat) begin
          dat_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      MHDR: begin
        hdrValid_out = 1'b1;
        if (hdrReady_in) state_nxt = MBODY;
      end
      MBODY: begin
        datValid_out = 1'b1;
        datData_out  = mtr_data;
        if (datReady_in) begin
          mtr_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      tlp_idx  <= '0;
      beat_cnt <= '0;
      f2c_pend <= 1'b0;
      c2f_pend <= 1'b0;
      mtr_c2f  <= 1'b0;
    end else begin
      if (start_dat)      beat_cnt <= '0;
      else if (beat_fire) beat_cnt <= beat_cnt + BEAT_W'(1);

      if (state == IDLE && !dmaEnable_in) begin
        wr_ptr   <= '0;
        tlp_idx  <= '0;
        f2c_pend <= 1'b0;
      end else if (dat_done) begin
        if (last_tlp) begin
          tlp_idx  <= '0;
          wr_ptr   <= wr_ptr + PTR_W'(1);
          f2c_pend <= 1'b1;
        end else begin
          tlp_idx <= tlp_idx + IDX_W'(1);
        end
      end else if (mtr_done && !mtr_c2f) begin
        f2c_pend <= 1'b0;
      end

      // A new update arriving with the final metric beat keeps the flag set
      if (c2fRdPtrUpd_in)             c2f_pend <= 1'b1;
      else if (mtr_done && mtr_c2f)   c2f_pend <= 1'b0;

      if (start_f2c)      mtr_c2f <= 1'b0;
      else if (start_c2f) mtr_c2f <= 1'b1;
    end
  end

  // Header fields and metric value are captured on leaving IDLE so they hold through the handshake
  always_ff @(posedge clk_in) begin
    if (start_dat) begin
      hdr_addr <= data_addr(f2cBase_in, wr_ptr, tlp_idx);
      hdr_dw   <= 10'(TLP_SIZE / 4);
    end else if (start_f2c) begin
      hdr_addr <= 64'(mtrBase_in) << 3;
      hdr_dw   <= 10'd1;
      mtr_data <= 64'(wr_ptr);
    end else if (start_c2f) begin
      hdr_addr <= (64'(mtrBase_in) << 3) + 64'd4;
      hdr_dw   <= 10'd1;
      mtr_data <= 64'(c2fRdPtr_in);
    end
  end

endmodule

// File: tb/tb_f2c_dma_sched.sv
// Directed bench for f2c_dma_sched: records header and beat handshakes and
// compares them with hand-computed address/data sequences.
module tb_f2c_dma_sched;

  logic        clk;
  logic        rstn;
  logic        en;
  logic [31:0] f2c_base, mtr_base;
  logic [1:0]  rdptr, c2f_ptr, wr_ptr;
  logic        c2f_upd;
  logic [63:0] f2c_data;
  logic        f2c_vld, f2c_rdy;
  logic        hdr_vld, hdr_rdy;
  logic [63:0] hdr_addr;
  logic [9:0]  hdr_dw;
  logic        dat_vld, dat_rdy;
  logic [63:0] dat_data;

  f2c_dma_sched dut (
    .clk_in(clk), .rstn(rstn), .dmaEnable_in(en),
    .f2cBase_in(f2c_base), .mtrBase_in(mtr_base), .rdPtr_in(rdptr),
    .c2fRdPtr_in(c2f_ptr), .c2fRdPtrUpd_in(c2f_upd),
    .f2cData_in(f2c_data), .f2cValid_in(f2c_vld), .f2cReady_out(f2c_rdy),
    .hdrValid_out(hdr_vld), .hdrReady_in(hdr_rdy), .hdrAddr_out(hdr_addr),
    .hdrDwCount_out(hdr_dw), .datValid_out(dat_vld), .datReady_in(dat_rdy),
    .datData_out(dat_data), .wrPtr_out(wr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] addr_q[$];
  logic [9:0]  dw_q[$];
  logic [63:0] beat_q[$];
  int src_idx, stall_left, pulse_a, pulse_b, sz;
  bit rnd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at posedge+1: drive inputs, sample at posedge+2, advance one clock
  task automatic cycle();
    c2f_upd  = 1'b0;
    dat_rdy  = (stall_left == 0);
    f2c_vld  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    hdr_rdy  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    f2c_data = 64'h0000_A000 + 64'(src_idx);
    #1;
    if (stall_left > 0) check("stall_rdy", 64'(f2c_rdy), 64'd0);
    if (hdr_vld && hdr_rdy) begin
      addr_q.push_back(hdr_addr);
      dw_q.push_back(hdr_dw);
    end
    if (dat_vld && dat_rdy) begin
      if (beat_q.size() == pulse_a) begin c2f_upd = 1'b1; c2f_ptr = 2'd2; end
      else if (beat_q.size() == pulse_b) begin c2f_upd = 1'b1; c2f_ptr = 2'd3; end
      beat_q.push_back(dat_data);
    end
    if (f2c_vld && f2c_rdy) src_idx++;
    if (stall_left > 0) stall_left--;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; en = 1'b0; rdptr = 2'd0; rnd = 1'b0; stall_left = 0;
    pulse_a = -1; pulse_b = -1; c2f_ptr = 2'd0; src_idx = 0;
    addr_q.delete(); dw_q.delete(); beat_q.delete();
    repeat (2) cycle();
    rstn = 1'b1;
  endtask

  task automatic wait_hdrs(input int n, input string tag);
    int k = 0;
    while (addr_q.size() < n && k < 3000) begin cycle(); k++; end
    check(tag, 64'(addr_q.size() >= n), 64'd1);
  endtask

  task automatic wait_beats(input int n, input string tag);
    int k = 0;
    while (beat_q.size() < n && k < 3000) begin cycle(); k++; end
    check(tag, 64'(beat_q.size() >= n), 64'd1);
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; f2c_base = 32'h0; mtr_base = 32'h200; rdptr = 2'd0;
    c2f_ptr = 2'd0; c2f_upd = 1'b0; f2c_data = 64'h0; f2c_vld = 1'b0;
    hdr_rdy = 1'b1; dat_rdy = 1'b1; rnd = 1'b0; stall_left = 0;
    pulse_a = -1; pulse_b = -1; src_idx = 0;
    @(posedge clk); #1;
    check("rst_hdr_vld", 64'(hdr_vld), 64'd0);
    check("rst_dat_vld", 64'(dat_vld), 64'd0);
    check("rst_f2c_rdy", 64'(f2c_rdy), 64'd0);
    check("rst_wr_ptr",  64'(wr_ptr),  64'd0);

    // One full chunk followed by its F2C metric
    do_reset();
    en = 1'b1;
    wait_beats(129, "chunk0_to");
    for (int i = 0; i < 8; i++) begin
      check("c0_addr", addr_q[i], 64'(i) * 64'h80);
      check("c0_dw", 64'(dw_q[i]), 64'd32);
    end
    check("c0_mtr_addr", addr_q[8], 64'h1000);
    check("c0_mtr_dw", 64'(dw_q[8]), 64'd1);
    for (int k = 0; k < 128; k++) check("c0_beat", beat_q[k], 64'h0000_A000 + 64'(k));
    check("c0_mtr_data", beat_q[128], 64'd1);
    check("c0_wr_ptr", 64'(wr_ptr), 64'd1);

    // Ring full with rdPtr=0, then release one slot
    do_reset();
    en = 1'b1;
    wait_hdrs(27, "full_to");
    repeat (60) cycle();
    check("full_hdr_cnt", 64'(addr_q.size()), 64'd27);
    check("full_wr_ptr", 64'(wr_ptr), 64'd3);
    rdptr = 2'd1;
    wait_hdrs(36, "c3_to");
    repeat (60) cycle();
    check("c3_hdr_cnt", 64'(addr_q.size()), 64'd36);
    check("c3_first", addr_q[27], 64'hC00);
    check("c3_last", addr_q[34], 64'hF80);
    check("c3_mtr_addr", addr_q[35], 64'h1000);
    check("c3_mtr_data", beat_q[515], 64'd0);

    // C2F update on final chunk beat, and again coincident with the C2F metric beat
    do_reset();
    en = 1'b1;
    pulse_a = 127;
    pulse_b = 129;
    wait_hdrs(12, "c2f_to");
    check("c2f_h8", addr_q[8], 64'h1000);
    check("c2f_h9", addr_q[9], 64'h1004);
    check("c2f_h9_dw", 64'(dw_q[9]), 64'd1);
    check("c2f_h10", addr_q[10], 64'h1004);
    check("c2f_h11", addr_q[11], 64'h400);
    check("c2f_b128", beat_q[128], 64'd1);
    check("c2f_b129", beat_q[129], 64'd2);
    check("c2f_b130", beat_q[130], 64'd3);

    // Backpressure stall with random source valid and header ready
    do_reset();
    en = 1'b1;
    rnd = 1'b1;
    wait_beats(5, "bp_start_to");
    stall_left = 10;
    repeat (10) cycle();
    check("bp_no_beats", 64'(beat_q.size() < 17), 64'd1);
    wait_beats(32, "bp_to");
    for (int k = 0; k < 32; k++) check("bp_beat", beat_q[k], 64'h0000_A000 + 64'(k));
    check("bp_h0", addr_q[0], 64'h0);
    check("bp_h1", addr_q[1], 64'h80);
    rnd = 1'b0;

    // Disable right after the 4th header of chunk 1
    do_reset();
    en = 1'b1;
    wait_hdrs(13, "dis_to");
    check("dis_h12", addr_q[12], 64'h580);
    check("dis_wr_before", 64'(wr_ptr), 64'd1);
    en = 1'b0;
    repeat (60) cycle();
    check("dis_hdr_cnt", 64'(addr_q.size()), 64'd13);
    check("dis_beat_cnt", 64'(beat_q.size()), 64'd193);
    check("dis_wr_ptr", 64'(wr_ptr), 64'd0);
    en = 1'b1;
    wait_hdrs(14, "reen_to");
    check("reen_addr", addr_q[13], 64'h0);

    // Asynchronous reset mid-body in chunk 1
    do_reset();
    en = 1'b1;
    wait_beats(134, "rst_mid_to");
    check("rst_mid_wr_before", 64'(wr_ptr), 64'd1);
    rstn = 1'b0;
    #1;
    check("rst_mid_hdr_vld", 64'(hdr_vld), 64'd0);
    check("rst_mid_dat_vld", 64'(dat_vld), 64'd0);
    check("rst_mid_f2c_rdy", 64'(f2c_rdy), 64'd0);
    check("rst_mid_wr_ptr",  64'(wr_ptr),  64'd0);
    en = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    sz = addr_q.size();
    repeat (6) cycle();
    check("rst_rel_no_hdr", 64'(addr_q.size()), 64'(sz));
    en = 1'b1;
    wait_hdrs(sz + 1, "rst_rel_to");
    check("rst_rel_addr", addr_q[sz], 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
